video_dotgen_scaled: RTL and testbench
======================================

Name: video_dotgen_scaled

Overview:
Parametrised successor to the PET character dot generator. It sits between the character-ROM fetch and the video output pin and serialises one glyph row per character cell. Additions over the original generator:
- configurable cell width
- per-cell horizontal pixel replication
- a pixel-clock enable
- an explicit empty/underrun state
- an optional hardware blink attribute

Parameters:
CHAR_WIDTH, 8, pixels per glyph row (4..16).
SCALE_MAX, 2, maximum horizontal replication factor (1..4).
BLINK_DIV_W, 5, width of the frame counter for blink; blink period is 2^BLINK_DIV_W frames.

Ports:
pixel_clk_i  in  1  pixel clock; all state updates on the rising edge.
reset_i  in  1  asynchronous, active-high reset.
pixel_en_i  in  1  pixel strobe; state advances only when high.
video_latch_i  in  1  load a new cell (qualified by pixel_en_i).
pixels_i  in  CHAR_WIDTH  glyph row, MSB is displayed first.
reverse_i  in  1  cell inverse-video attribute.
blink_i  in  1  cell blink attribute.
hscale_i  in  $clog2(SCALE_MAX) (minimum 1)  replication minus one; each pixel shows hscale_i+1 times.
display_en_i  in  1  raster display enable; applied combinationally at the output.
frame_start_i  in  1  one-clock pulse per frame for the blink counter.
video_o  out  1  serial video.
busy_o  out  1  the shifter holds undisplayed pixels.
underrun_o  out  1  sticky flag: the cell ran out before the next latch.

Behaviour:
- Reset (asynchronous): shift register, attributes, counters and flags all clear. video_o=0, busy_o=0, underrun_o=0. State EMPTY.
- States:
  - EMPTY: video_o = display_en_i & reverse_q; blank is shown as background.
  - SHIFT: video_o = display_en_i & (glyph_bit ^ reverse_q).
- Cycles with pixel_en_i=0 freeze all state except the blink counter. video_o stays combinational from the held state.
- Latch: in a cycle with pixel_en_i & video_latch_i, the block captures pixels_i, reverse_i, blink_i and hscale_i. It clears the repeat and pixel counters and enters SHIFT. The first pixel appears on video_o after that edge, i.e. one pixel_clk_i of latency.
- Advance (SHIFT, pixel_en_i=1, no latch):
  - repeat counter < scale_q: increment the repeat counter.
  - otherwise: clear the repeat counter, shift left with zero fill and increment the pixel counter.
- Exhaustion: the last pixel completes on the final repeat of pixel CHAR_WIDTH-1. Without a latch in that cycle, the block goes to EMPTY and sets underrun_o. A latch arriving on the exhaustion cycle has priority, so there is no underrun.
- An early latch, before exhaustion, truncates the current cell. This is legal and not flagged.
- hscale_i changes affect only subsequent latches. Values above SCALE_MAX-1 saturate to SCALE_MAX-1.
- busy_o=1 exactly in SHIFT.
- underrun_o clears only on reset.
- Counter widths:
  - pixel counter: $clog2(CHAR_WIDTH)
  - repeat counter: $clog2(SCALE_MAX), minimum 1
  - Both wrap only through the rules above and never free-run.

Optional Feature:
VIDEO_DOTGEN_BLINK_EN.
- Defined: a BLINK_DIV_W-bit frame counter increments on every clock with frame_start_i=1, independent of pixel_en_i, and resets to 0. blink_phase is the counter MSB. While blink_q & blink_phase, glyph_bit is forced to 0 and reverse still applies, so a blinking reversed cell shows solid background-inverse.
- Undefined: blink_i and frame_start_i are ignored, and neither the counter nor blink_q exists.

Decomposition:
- Package video_pkg holds the CHAR_WIDTH default, the SCALE_MAX default, the dotgen_state_e enum {EMPTY, SHIFT}, and the function clamp_scale().
- One sub-module, video_blink_ctr: the frame counter that produces blink_phase, instantiated only under VIDEO_DOTGEN_BLINK_EN.

Test Plan:
1. CHAR_WIDTH=8, hscale 0, pixel_en_i=1: latch 8'hA5 with reverse 0 and display_en_i=1. Expect video_o 1,0,1,0,0,1,0,1 on the 8 cycles after the latch, then EMPTY, busy_o=0 and underrun_o=1.
2. Latch 8'hF0 with hscale 1 and reverse 1, then relatch every 16 cycles. Expect video_o = eight 0s then eight 1s, repeating, with underrun_o staying 0.
3. Toggle pixel_en_i every other cycle during an 8'h81 cell. Expect each pixel held for 2 clocks, total cell length 16 clocks, output 1,1,0x12,1,1.
4. Latch 8'hFF, then assert reset_i asynchronously mid-cell at pixel 3. Expect video_o=0, busy_o=0 and underrun_o=0 immediately, before the next edge.
5. Latch on exactly the exhaustion cycle (cycle 8) with 8'h00 and reverse 1. Expect seamless continuation: 8 pixels of 1, underrun_o stays 0, busy_o never drops.
6. With VIDEO_DOTGEN_BLINK_EN and BLINK_DIV_W=2: blink_i=1, pixels 8'hFF, relatch continuously. Expect frames 0-1 show 1s, frames 2-3 show 0s. Without the macro, all frames show 1s.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and helpers for the scaled dot generator.
// Holds the default geometry, the shifter state enum, and the scale clamp helper.
package video_pkg;

  localparam int CHAR_WIDTH_DEF = 8;
  localparam int SCALE_MAX_DEF  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } dotgen_state_e;

  // Saturate a requested replication-minus-one value to the largest legal setting.
  function automatic int unsigned clamp_scale(input int unsigned hscale,
                                              input int unsigned scale_max);
    return (hscale > scale_max - 1) ? scale_max - 1 : hscale;
  endfunction

endpackage

// File: rtl/video_blink_ctr.sv
// Frame counter for the blink attribute; counts frame_start pulses regardless of pixel strobe.
// blink_phase is the counter MSB, so the period is 2^BLINK_DIV_W frames.
module video_blink_ctr #(
  parameter int BLINK_DIV_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic blink_phase
);

  logic [BLINK_DIV_W-1:0] frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (frame_start) begin
      frame_q <= frame_q + BLINK_DIV_W'(1);
    end
  end

  assign blink_phase = frame_q[BLINK_DIV_W-1];

endmodule

// File: rtl/video_dotgen_scaled.sv
// Serialises one glyph row per character cell with per-cell horizontal replication and a sticky underrun flag.
// Optional hardware blink attribute is enabled by defining VIDEO_DOTGEN_BLINK_EN.
module video_dotgen_scaled
  import video_pkg::*;
#(
  parameter  int CHAR_WIDTH  = CHAR_WIDTH_DEF,
  parameter  int SCALE_MAX   = SCALE_MAX_DEF,
  parameter  int BLINK_DIV_W = 5,
  localparam int SCALE_W     = (SCALE_MAX > 1) ? $clog2(SCALE_MAX) : 1
) (
  input  logic                  pixel_clk_i,
  input  logic                  reset_i,
  input  logic                  pixel_en_i,
  input  logic                  video_latch_i,
  input  logic [CHAR_WIDTH-1:0] pixels_i,
  input  logic                  reverse_i,
  input  logic                  blink_i,
  input  logic [SCALE_W-1:0]    hscale_i,
  input  logic                  display_en_i,
  input  logic                  frame_start_i,
  output logic                  video_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int PIX_W = $clog2(CHAR_WIDTH);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(CHAR_WIDTH - 1);

  dotgen_state_e state_q, state_d;

  logic [CHAR_WIDTH-1:0] shift_q;
  logic                  reverse_q;
  logic [SCALE_W-1:0]    scale_q;
  logic [SCALE_W-1:0]    rep_q;
  logic [PIX_W-1:0]      pix_q;
  logic                  underrun_q;

  logic latch;
  logic advance;
  logic last_repeat;
  logic cell_done;
  logic glyph_bit;
  logic blank;

  assign latch       = pixel_en_i & video_latch_i;
  assign advance     = pixel_en_i & ~video_latch_i & (state_q == SHIFT);
  assign last_repeat = (rep_q == scale_q);
  assign cell_done   = last_repeat & (pix_q == PIX_LAST);

`ifdef VIDEO_DOTGEN_BLINK_EN
  logic blink_q;
  logic blink_phase;

  video_blink_ctr #(
    .BLINK_DIV_W(BLINK_DIV_W)
  ) u_blink_ctr (
    .clk        (pixel_clk_i),
    .rst        (reset_i),
    .frame_start(frame_start_i),
    .blink_phase(blink_phase)
  );

  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      blink_q <= 1'b0;
    end else if (latch) begin
      blink_q <= blink_i;
    end
  end

  assign blank = blink_q & blink_phase;
`else
  logic [BLINK_DIV_W-1:0] unused_blink;
  assign unused_blink = {BLINK_DIV_W{blink_i & frame_start_i}};
  assign blank        = 1'b0;
`endif

  // State register
  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a latch always wins, even on the exhaustion cycle.
  always_comb begin
    state_d = state_q;
    if (latch) begin
      state_d = SHIFT;
    end else if (advance && cell_done) begin
      state_d = EMPTY;
    end
  end

  // Outputs
  always_comb begin
    glyph_bit = shift_q[CHAR_WIDTH-1] & ~blank;
    busy_o    = 1'b0;
    video_o   = display_en_i & reverse_q;
    if (state_q == SHIFT) begin
      busy_o  = 1'b1;
      video_o = display_en_i & (glyph_bit ^ reverse_q);
    end
  end

  assign underrun_o = underrun_q;

  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q    <= '0;
      reverse_q  <= 1'b0;
      scale_q    <= '0;
      rep_q      <= '0;
      pix_q      <= '0;
      underrun_q <= 1'b0;
    end else if (latch) begin
      shift_q   <= pixels_i;
      reverse_q <= reverse_i;
      scale_q   <= SCALE_W'(clamp_scale(32'(hscale_i), SCALE_MAX));
      rep_q     <= '0;
      pix_q     <= '0;
    end else if (advance) begin
      if (!last_repeat) begin
        rep_q <= rep_q + SCALE_W'(1);
      end else begin
        rep_q   <= '0;
        shift_q <= {shift_q[CHAR_WIDTH-2:0], 1'b0};
        if (cell_done) begin
          pix_q      <= '0;
          underrun_q <= 1'b1;
        end else begin
          pix_q <= pix_q + PIX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_dotgen_scaled.sv
// Directed plus randomized bench for video_dotgen_scaled against a position-based cell model.
// Runs with CHAR_WIDTH=8, SCALE_MAX=3, BLINK_DIV_W=2.
module tb_video_dotgen_scaled;

  localparam int CW  = 8;
  localparam int SM  = 3;
  localparam int BDW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, latch = 1'b0, rev = 1'b0, blk = 1'b0, de = 1'b0, fs = 1'b0;
  logic [7:0] pix = '0;
  logic [1:0] hs = '0;
  logic       video, busy, under;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: a cell is a pixel vector plus a count of enabled advances since its latch.
  logic       m_active, m_rev, m_blink, m_under;
  logic [7:0] m_pix;
  int         m_scale, m_pos, m_frames;

  video_dotgen_scaled #(
    .CHAR_WIDTH (CW),
    .SCALE_MAX  (SM),
    .BLINK_DIV_W(BDW)
  ) dut (
    .pixel_clk_i  (clk),
    .reset_i      (rst),
    .pixel_en_i   (en),
    .video_latch_i(latch),
    .pixels_i     (pix),
    .reverse_i    (rev),
    .blink_i      (blk),
    .hscale_i     (hs),
    .display_en_i (de),
    .frame_start_i(fs),
    .video_o      (video),
    .busy_o       (busy),
    .underrun_o   (under)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_rev = 1'b0; m_blink = 1'b0; m_under = 1'b0;
    m_pix = '0; m_scale = 0; m_pos = 0; m_frames = 0;
  endtask

  task automatic model_edge();
    if (fs) m_frames++;
    if (en) begin
      if (latch) begin
        m_active = 1'b1; m_pix = pix; m_rev = rev; m_blink = blk; m_pos = 0;
        m_scale  = (int'(hs) > SM - 1) ? SM - 1 : int'(hs);
      end else if (m_active) begin
        if (m_pos == CW * (m_scale + 1) - 1) begin
          m_active = 1'b0;
          m_under  = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  function automatic logic exp_video();
    logic bit_v;
    logic phase;
    phase = 1'b0;
`ifdef VIDEO_DOTGEN_BLINK_EN
    phase = (m_frames % (1 << BDW)) >= (1 << (BDW - 1));
`endif
    bit_v = m_pix[CW - 1 - m_pos / (m_scale + 1)] & ~(m_blink & phase);
    return de & (m_active ? (bit_v ^ m_rev) : m_rev);
  endfunction

  task automatic check_out(input string tag);
    chk({tag, ".video"}, video, exp_video());
    chk({tag, ".busy"}, busy, m_active);
    chk({tag, ".under"}, under, m_under);
  endtask

  task automatic cyc(input string tag, input logic e, input logic l, input logic [7:0] p,
                     input logic r, input logic b, input logic [1:0] h, input logic d,
                     input logic f);
    en = e; latch = l; pix = p; rev = r; blk = b; hs = h; de = d; fs = f;
    @(posedge clk);
    model_edge();
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #2;
    chk({tag, ".video"}, video, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".under"}, under, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] a5_pat;
    a5_pat = 8'hA5;
    model_reset();
    do_reset("reset");

    // A5 at scale 1x, then exhaustion
    cyc("t1_latch", 1, 1, 8'hA5, 0, 0, 2'd0, 1, 0);
    chk("t1_first_px", video, a5_pat[7]);
    for (int i = 0; i < 7; i++) cyc("t1_px", 1, 0, 8'h00, 0, 0, 2'd0, 1, 0);
    chk("t1_last_px", video, a5_pat[0]);
    cyc("t1_empty", 1, 0, 8'h00, 0, 0, 2'd0, 1, 0);
    chk("t1_underrun", under, 1'b1);
    chk("t1_idle", busy, 1'b0);

    // F0 doubled, reversed, relatched every 16 pixels
    do_reset("t2_reset");
    for (int c = 0; c < 3; c++) begin
      cyc("t2_latch", 1, 1, 8'hF0, 1, 0, 2'd1, 1, 0);
      for (int i = 0; i < 15; i++) cyc("t2_px", 1, 0, 8'h00, 1, 0, 2'd1, 1, 0);
      chk("t2_tail_bg", video, 1'b1);
    end
    chk("t2_no_underrun", under, 1'b0);

    // 81 with pixel strobe every other clock
    do_reset("t3_reset");
    cyc("t3_latch", 1, 1, 8'h81, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 16; i++) cyc("t3_px", i[0], 0, 8'h00, 0, 0, 2'd0, 1, 0);
    chk("t3_done", busy, 1'b0);

    // Async reset mid-cell
    do_reset("t4_pre");
    cyc("t4_latch", 1, 1, 8'hFF, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("t4_px", 1, 0, 8'h00, 0, 0, 2'd0, 1, 0);
    do_reset("t4_async");

    // Latch exactly on the exhaustion cycle
    cyc("t5_latch", 1, 1, 8'hA5, 0, 0, 2'd0, 1, 0);
    for (int i = 0; i < 7; i++) cyc("t5_px", 1, 0, 8'h00, 0, 0, 2'd0, 1, 0);
    cyc("t5_relatch", 1, 1, 8'h00, 1, 0, 2'd0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      cyc("t5_cont", 1, 0, 8'h00, 1, 0, 2'd0, 1, 0);
      chk("t5_busy", busy, 1'b1);
      chk("t5_video", video, 1'b1);
    end
    chk("t5_no_underrun", under, 1'b0);

    // Blink: two cells per frame over four frames, frame pulse on each frame's last clock
    do_reset("t6_reset");
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 2; c++) begin
        cyc("t6_latch", 1, 1, 8'hFF, 0, 1, 2'd0, 1, 0);
        for (int i = 0; i < 7; i++)
          cyc("t6_px", 1, 0, 8'h00, 0, 1, 2'd0, 1, (c == 1 && i == 6) ? 1'b1 : 1'b0);
      end
    end

    // Randomized traffic, including saturating hscale and display blanking
    do_reset("rand_reset");
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset("rand_mid_reset");
      cyc("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
          8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
